// File: rtl/mont_seq_pkg.sv
// -----------------------------------------------------------------------------
// mont_seq_pkg
// Shared types and constants for the Montgomery operand sequencer.
//   state_t        : sequencer FSM states
//   RUN_CNT_WIDTH  : width of the run-cycle performance counter
//   RUN_CNT_MAX    : saturation value of the run-cycle counter
//   sat_inc()      : saturating increment for the run-cycle counter
// -----------------------------------------------------------------------------
package mont_seq_pkg;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_M,
    S_START,
    S_RUN,
    S_WRITE
  } state_t;

  localparam int RUN_CNT_WIDTH = 32;
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_CNT_MAX = '1;

  function automatic logic [RUN_CNT_WIDTH-1:0] sat_inc(input logic [RUN_CNT_WIDTH-1:0] value);
    return (value == RUN_CNT_MAX) ? value : value + RUN_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mont_seq_lane.sv
// -----------------------------------------------------------------------------
// mont_seq_lane
// Per-core storage: the three latched operands, the latched result and the
// "this core has finished" flag.
//   clk, reset        : clock, synchronous active-high reset
//   load_a/b/m        : capture frame into the matching operand register
//   frame             : operand frame slice for this core
//   clear             : clear the done flag (start of a new run)
//   capture           : latch result and set the done flag
//   result            : core result, valid with capture
//   op_a/op_b/op_m    : latched operands
//   result_out        : latched result
//   done_flag         : core has reported completion in the current run
// -----------------------------------------------------------------------------
module mont_seq_lane
  import mont_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_a,
  input  logic                  load_b,
  input  logic                  load_m,
  input  logic [DATA_WIDTH-1:0] frame,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] op_m,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  done_flag
);

  // NOTE: these wide registers are plain flops, not RAM, so they take the
  // reset like any other state; software expects zeroed operands after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      op_m       <= '0;
      result_out <= '0;
      done_flag  <= 1'b0;
    end else begin
      if (load_a) op_a <= frame;
      if (load_b) op_b <= frame;
      if (load_m) op_m <= frame;
      if (clear) begin
        done_flag <= 1'b0;
      end else if (capture) begin
        result_out <= result;
        done_flag  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mont_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mont_operand_sequencer
// Collects A, B and M frames from the operand RAM, starts the Montgomery
// core(s), waits until every active core has finished, then writes the
// results back to the RAM until it acknowledges. Counts cycles spent running.
//   clk, reset                 : clock, synchronous active-high reset
//   frame_in1/2, frame_valid   : RAM parallel output and its new-frame pulse
//   op_a1/b1/m1, op_a2/b2/m2   : latched operands per core
//   core_start                 : one-cycle start pulse to all cores
//   core_done1/2, core_result1/2 : per-core completion pulse and result
//   result_out1/2, result_we   : results and write enable to the RAM
//   result_read                : RAM ack that the write landed
//   busy                       : high whenever not waiting for operand A
//   overrun                    : sticky, a frame arrived while not loading
//   run_cycles                 : cycles spent running, saturating
// With NUM_OF_CORES == 1 all core-2 inputs are ignored and outputs tied to 0.
// -----------------------------------------------------------------------------
module mont_operand_sequencer
  import mont_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int NUM_OF_CORES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    frame_in1,
  input  logic [DATA_WIDTH-1:0]    frame_in2,
  input  logic                     frame_valid,
  output logic [DATA_WIDTH-1:0]    op_a1,
  output logic [DATA_WIDTH-1:0]    op_b1,
  output logic [DATA_WIDTH-1:0]    op_m1,
  output logic [DATA_WIDTH-1:0]    op_a2,
  output logic [DATA_WIDTH-1:0]    op_b2,
  output logic [DATA_WIDTH-1:0]    op_m2,
  output logic                     core_start,
  input  logic                     core_done1,
  input  logic                     core_done2,
  input  logic [DATA_WIDTH-1:0]    core_result1,
  input  logic [DATA_WIDTH-1:0]    core_result2,
  output logic [DATA_WIDTH-1:0]    result_out1,
  output logic [DATA_WIDTH-1:0]    result_out2,
  output logic                     result_we,
  input  logic                     result_read,
  output logic                     busy,
  output logic                     overrun,
  output logic [RUN_CNT_WIDTH-1:0] run_cycles
);

  state_t                   state;
  logic [RUN_CNT_WIDTH-1:0] run_cnt;

  logic load_a, load_b, load_m;
  logic clear_flags, in_run;
  logic capture1, done_flag1, done_now1, done_now2;
  logic all_done;
  logic frame_dropped;

  assign load_a      = frame_valid && (state == S_LOAD_A);
  assign load_b      = frame_valid && (state == S_LOAD_B);
  assign load_m      = frame_valid && (state == S_LOAD_M);
  assign clear_flags = (state == S_START);
  assign in_run      = (state == S_RUN);
  assign capture1    = in_run && core_done1;

  assign frame_dropped = frame_valid &&
                         ((state == S_START) || (state == S_RUN) || (state == S_WRITE));

  // Decoded straight from the state register: no input reaches an output.
  assign core_start = (state == S_START);
  assign result_we  = (state == S_WRITE);
  assign busy       = (state != S_LOAD_A);
  assign run_cycles = run_cnt;

  mont_seq_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane1 (
    .clk        (clk),
    .reset      (reset),
    .load_a     (load_a),
    .load_b     (load_b),
    .load_m     (load_m),
    .frame      (frame_in1),
    .clear      (clear_flags),
    .capture    (capture1),
    .result     (core_result1),
    .op_a       (op_a1),
    .op_b       (op_b1),
    .op_m       (op_m1),
    .result_out (result_out1),
    .done_flag  (done_flag1)
  );

  // A done pulse arriving this cycle counts as finished, so simultaneous
  // completions leave S_RUN without an extra cycle.
  assign done_now1 = done_flag1 | core_done1;

  generate
    if (NUM_OF_CORES == 2) begin : g_core2
      logic capture2;
      logic done_flag2;

      assign capture2 = in_run && core_done2;

      mont_seq_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane2 (
        .clk        (clk),
        .reset      (reset),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_m     (load_m),
        .frame      (frame_in2),
        .clear      (clear_flags),
        .capture    (capture2),
        .result     (core_result2),
        .op_a       (op_a2),
        .op_b       (op_b2),
        .op_m       (op_m2),
        .result_out (result_out2),
        .done_flag  (done_flag2)
      );

      assign done_now2 = done_flag2 | core_done2;
    end else begin : g_no_core2
      // Core-2 inputs are deliberately ignored in single-core builds.
      logic unused_core2;
      assign unused_core2 = ^{frame_in2, core_result2, core_done2};

      assign op_a2       = '0;
      assign op_b2       = '0;
      assign op_m2       = '0;
      assign result_out2 = '0;
      assign done_now2   = 1'b1;
    end
  endgenerate

  assign all_done = done_now1 & done_now2;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before this edge regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_LOAD_A;
      run_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A: if (frame_valid) state <= S_LOAD_B;
        S_LOAD_B: if (frame_valid) state <= S_LOAD_M;
        S_LOAD_M: if (frame_valid) state <= S_START;
        S_START: begin
          run_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= sat_inc(run_cnt);
          if (all_done) state <= S_WRITE;
        end
        S_WRITE:  if (result_read) state <= S_LOAD_A;
        default:  state <= S_LOAD_A;
      endcase

      if (frame_dropped) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mont_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mont_operand_sequencer
// Drives a single-core and a dual-core sequencer from the same stimulus and
// compares both against an operation-level reference model: each operation
// is described by its operands, per-core done times, results and ack delay,
// from which the expected finish cycle, write-enable length, run count and
// final register contents follow.
// -----------------------------------------------------------------------------
module tb_mont_operand_sequencer;
  import mont_seq_pkg::*;

  localparam int DW = 512;
  typedef logic [DW-1:0] word_t;

  typedef struct {
    word_t       a1, a2, b1, b2, m1, m2, r1, r2;
    int          d1, d2, ack, stray;
    bit          sat;
    logic [31:0] run0, run1;
    int          we0, we1;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  word_t frame_in1, frame_in2, core_result1, core_result2;
  logic  frame_valid, core_done1, core_done2, result_read;

  word_t       op_a1_o[2], op_b1_o[2], op_m1_o[2];
  word_t       op_a2_o[2], op_b2_o[2], op_m2_o[2];
  word_t       res1_o[2], res2_o[2];
  logic        core_start_o[2], result_we_o[2], busy_o[2], overrun_o[2];
  logic [31:0] run_cycles_o[2];

  always #5 clk = ~clk;

  mont_operand_sequencer #(.DATA_WIDTH(DW), .NUM_OF_CORES(1)) dut0 (
    .clk(clk), .reset(reset),
    .frame_in1(frame_in1), .frame_in2(frame_in2), .frame_valid(frame_valid),
    .op_a1(op_a1_o[0]), .op_b1(op_b1_o[0]), .op_m1(op_m1_o[0]),
    .op_a2(op_a2_o[0]), .op_b2(op_b2_o[0]), .op_m2(op_m2_o[0]),
    .core_start(core_start_o[0]),
    .core_done1(core_done1), .core_done2(core_done2),
    .core_result1(core_result1), .core_result2(core_result2),
    .result_out1(res1_o[0]), .result_out2(res2_o[0]),
    .result_we(result_we_o[0]), .result_read(result_read),
    .busy(busy_o[0]), .overrun(overrun_o[0]), .run_cycles(run_cycles_o[0])
  );

  mont_operand_sequencer #(.DATA_WIDTH(DW), .NUM_OF_CORES(2)) dut1 (
    .clk(clk), .reset(reset),
    .frame_in1(frame_in1), .frame_in2(frame_in2), .frame_valid(frame_valid),
    .op_a1(op_a1_o[1]), .op_b1(op_b1_o[1]), .op_m1(op_m1_o[1]),
    .op_a2(op_a2_o[1]), .op_b2(op_b2_o[1]), .op_m2(op_m2_o[1]),
    .core_start(core_start_o[1]),
    .core_done1(core_done1), .core_done2(core_done2),
    .core_result1(core_result1), .core_result2(core_result2),
    .result_out1(res1_o[1]), .result_out2(res2_o[1]),
    .result_we(result_we_o[1]), .result_read(result_read),
    .busy(busy_o[1]), .overrun(overrun_o[1]), .run_cycles(run_cycles_o[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, shared stimulus so one operand set covers both DUTs.
  word_t       m_a1, m_b1, m_m1, m_a2, m_b2, m_m2;
  word_t       m_res1[2], m_res2[2];
  logic        m_ovr;
  logic [31:0] m_run[2];

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic clear_inputs();
    frame_valid = 1'b0;
    core_done1  = 1'b0;
    core_done2  = 1'b0;
    result_read = 1'b0;
  endtask

  task automatic model_reset();
    m_a1 = '0; m_b1 = '0; m_m1 = '0;
    m_a2 = '0; m_b2 = '0; m_m2 = '0;
    for (int c = 0; c < 2; c++) begin
      m_res1[c] = '0;
      m_res2[c] = '0;
      m_run[c]  = '0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s d%0d op_a1", tag, c), op_a1_o[c], m_a1);
      check($sformatf("%s d%0d op_b1", tag, c), op_b1_o[c], m_b1);
      check($sformatf("%s d%0d op_m1", tag, c), op_m1_o[c], m_m1);
      check($sformatf("%s d%0d op_a2", tag, c), op_a2_o[c], (c == 1) ? m_a2 : '0);
      check($sformatf("%s d%0d op_b2", tag, c), op_b2_o[c], (c == 1) ? m_b2 : '0);
      check($sformatf("%s d%0d op_m2", tag, c), op_m2_o[c], (c == 1) ? m_m2 : '0);
      check($sformatf("%s d%0d result_out1", tag, c), res1_o[c], m_res1[c]);
      check($sformatf("%s d%0d result_out2", tag, c), res2_o[c], m_res2[c]);
      check($sformatf("%s d%0d overrun", tag, c), word_t'(overrun_o[c]), word_t'(m_ovr));
      check($sformatf("%s d%0d run_cycles", tag, c), word_t'(run_cycles_o[c]), word_t'(m_run[c]));
    end
  endtask

  // One frame pulse after a short random gap; stray done pulses ride along
  // and must be ignored because no DUT is in S_RUN while loading.
  task automatic load_frame(input word_t f1, input word_t f2);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      clear_inputs();
    end
    frame_valid  = 1'b1;
    frame_in1    = f1;
    frame_in2    = f2;
    core_done1   = 1'b1;
    core_done2   = 1'b1;
    core_result1 = rand_word();
    core_result2 = rand_word();
    @(negedge clk);
    clear_inputs();
  endtask

  // Operation-level model: the single-core DUT finishes on done1, the
  // dual-core DUT on the later of the two dones; both see the ack together.
  function automatic vec_t model_fill(input vec_t v);
    vec_t r;
    int   f1, w;
    r  = v;
    f1 = (v.d1 > v.d2) ? v.d1 : v.d2;
    w  = f1 + 1 + v.ack;
    r.we0  = w - v.d1;
    r.we1  = w - f1;
    r.run0 = v.sat ? 32'hFFFF_FFFF : 32'(v.d1);
    r.run1 = v.sat ? 32'hFFFF_FFFF : 32'(f1);
    return r;
  endfunction

  function automatic vec_t mk(input word_t a1, a2, b1, b2, m1, m2, r1, r2,
                              input int d1, d2, ack, stray, input bit sat,
                              input logic [31:0] run0, run1, input int we0, we1);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.b1 = b1; v.b2 = b2; v.m1 = m1; v.m2 = m2;
    v.r1 = r1; v.r2 = r2;
    v.d1 = d1; v.d2 = d2; v.ack = ack; v.stray = stray; v.sat = sat;
    v.run0 = run0; v.run1 = run1; v.we0 = we0; v.we1 = we1;
    return v;
  endfunction

  function automatic vec_t mk_rand();
    vec_t v;
    int   w;
    v.a1 = rand_word(); v.a2 = rand_word(); v.b1 = rand_word();
    v.b2 = rand_word(); v.m1 = rand_word(); v.m2 = rand_word();
    v.r1 = rand_word(); v.r2 = rand_word();
    v.d1  = $urandom_range(1, 20);
    v.d2  = $urandom_range(1, 20);
    v.ack = $urandom_range(0, 4);
    v.sat = 1'b0;
    w = ((v.d1 > v.d2) ? v.d1 : v.d2) + 1 + v.ack;
    v.stray = ($urandom_range(0, 2) == 0) ? $urandom_range(1, w) : 0;
    return model_fill(v);
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    int f[2];
    int w;
    int we_cnt[2];
    f[0] = v.d1;
    f[1] = (v.d1 > v.d2) ? v.d1 : v.d2;
    w    = f[1] + 1 + v.ack;
    we_cnt[0] = 0;
    we_cnt[1] = 0;

    load_frame(v.a1, v.a2);
    for (int c = 0; c < 2; c++)
      check($sformatf("%s d%0d busy after A", tag, c), word_t'(busy_o[c]), word_t'(1'b1));
    load_frame(v.b1, v.b2);
    for (int c = 0; c < 2; c++)
      check($sformatf("%s d%0d start before M", tag, c), word_t'(core_start_o[c]), word_t'(1'b0));
    // The M load returns on the negedge of the cycle after the M edge.
    frame_valid = 1'b1; frame_in1 = v.m1; frame_in2 = v.m2;
    @(negedge clk);
    clear_inputs();
    m_a1 = v.a1; m_b1 = v.b1; m_m1 = v.m1;
    m_a2 = v.a2; m_b2 = v.b2; m_m2 = v.m2;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s d%0d core_start", tag, c), word_t'(core_start_o[c]), word_t'(1'b1));
      check($sformatf("%s d%0d op_m1", tag, c), op_m1_o[c], m_m1);
      check($sformatf("%s d%0d op_m2", tag, c), op_m2_o[c], (c == 1) ? m_m2 : '0);
    end

    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      clear_inputs();
      for (int c = 0; c < 2; c++) begin
        if (k == 1)
          check($sformatf("%s d%0d start pulse ends", tag, c), word_t'(core_start_o[c]), word_t'(1'b0));
        if (result_we_o[c]) we_cnt[c]++;
        if (k == f[c] + 1) begin
          check($sformatf("%s d%0d result_we on entry", tag, c), word_t'(result_we_o[c]), word_t'(1'b1));
          check($sformatf("%s d%0d run_cycles", tag, c), word_t'(run_cycles_o[c]),
                word_t'((c == 0) ? v.run0 : v.run1));
          check($sformatf("%s d%0d result_out1", tag, c), res1_o[c], v.r1);
          check($sformatf("%s d%0d result_out2", tag, c), res2_o[c], (c == 1) ? v.r2 : '0);
        end
      end
      if (v.sat && k == 1) begin
        force dut0.run_cnt = 32'hFFFF_FFFC;
        force dut1.run_cnt = 32'hFFFF_FFFC;
        #1;
        release dut0.run_cnt;
        release dut1.run_cnt;
      end
      core_done1   = (k == v.d1);
      core_done2   = (k == v.d2);
      core_result1 = (k == v.d1) ? v.r1 : rand_word();
      core_result2 = (k == v.d2) ? v.r2 : rand_word();
      frame_valid  = (k == v.stray);
      frame_in1    = rand_word();
      frame_in2    = rand_word();
      result_read  = (k == w);
    end

    @(negedge clk);
    clear_inputs();
    m_res1[0] = v.r1; m_res1[1] = v.r1;
    m_res2[0] = '0;   m_res2[1] = v.r2;
    m_run[0]  = v.run0;
    m_run[1]  = v.run1;
    if (v.stray != 0) m_ovr = 1'b1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s d%0d result_we cycles", tag, c), word_t'(we_cnt[c]),
            word_t'((c == 0) ? v.we0 : v.we1));
      check($sformatf("%s d%0d result_we after ack", tag, c), word_t'(result_we_o[c]), word_t'(1'b0));
      check($sformatf("%s d%0d busy after ack", tag, c), word_t'(busy_o[c]), word_t'(1'b0));
    end
    check_state(tag);
  endtask

  task automatic reset_mid_run();
    load_frame(rand_word(), rand_word());
    load_frame(rand_word(), rand_word());
    load_frame(rand_word(), rand_word());
    repeat (3) begin
      @(negedge clk);
      clear_inputs();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rst d%0d busy", c), word_t'(busy_o[c]), word_t'(1'b0));
      check($sformatf("rst d%0d core_start", c), word_t'(core_start_o[c]), word_t'(1'b0));
      check($sformatf("rst d%0d result_we", c), word_t'(result_we_o[c]), word_t'(1'b0));
    end
    check_state("rst");
    core_done1   = 1'b1;
    core_done2   = 1'b1;
    core_result1 = rand_word();
    core_result2 = rand_word();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      for (int c = 0; c < 2; c++) begin
        check($sformatf("rst late done d%0d result_we", c), word_t'(result_we_o[c]), word_t'(1'b0));
        check($sformatf("rst late done d%0d busy", c), word_t'(busy_o[c]), word_t'(1'b0));
      end
    end
    check_state("rst late done");
  endtask

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    frame_in1 = '0; frame_in2 = '0; core_result1 = '0; core_result2 = '0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("reset d%0d busy", c), word_t'(busy_o[c]), word_t'(1'b0));
      check($sformatf("reset d%0d core_start", c), word_t'(core_start_o[c]), word_t'(1'b0));
      check($sformatf("reset d%0d result_we", c), word_t'(result_we_o[c]), word_t'(1'b0));
    end
    check_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed operations with hand-derived expectations:
    //                a1     a2     b1     b2     m1     m2     r1     r2
    //                d1 d2 ack stray sat  run0 run1 we0 we1
    vecs.push_back(mk('h3, 'h13, 'h5, 'h15, 'h7, 'h17, 'h1, 'h2,
                      10, 10, 3, 0, 1'b0, 10, 10, 4, 4));
    vecs.push_back(mk('h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'hBB, 'hAA,
                      8, 5, 0, 0, 1'b0, 8, 8, 1, 1));
    vecs.push_back(mk('h31, 'h32, 'h33, 'h34, 'h35, 'h36, 'hC1, 'hC2,
                      4, 4, 1, 0, 1'b0, 4, 4, 2, 2));
    vecs.push_back(mk('h41, 'h42, 'h43, 'h44, 'h45, 'h46, 'hD1, 'hD2,
                      3, 7, 0, 0, 1'b0, 3, 7, 5, 1));
    vecs.push_back(mk('h51, 'h52, 'h53, 'h54, 'h55, 'h56, 'hE1, 'hE2,
                      6, 2, 2, 3, 1'b0, 6, 6, 3, 3));
    vecs.push_back(mk('h61, 'h62, 'h63, 'h64, 'h65, 'h66, 'hF1, 'hF2,
                      1, 1, 0, 0, 1'b0, 1, 1, 1, 1));
    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) do_op(mk_rand(), $sformatf("rand%0d", i));

    reset_mid_run();
    do_op(mk_rand(), "after rst");

    do_op(mk(rand_word(), rand_word(), rand_word(), rand_word(), rand_word(), rand_word(),
             'h5A, 'hA5, 6, 6, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1), "sat");

    do_op(mk_rand(), "final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
